// File: rtl/debounce_edge_qualifier_if.sv
// debounce_edge_qualifier_if: debounced-level input, controls and edge/count/period results
interface debounce_edge_qualifier_if #(
  parameter int HOLDOFF_W = 8,
  parameter int CNT_W     = 16,
  parameter int PER_W     = 24
);
  logic                 din;
  logic                 enable;
  logic [HOLDOFF_W-1:0] holdoff;
  logic                 clear;
  logic                 edge_pulse;
  logic                 busy;
  logic [CNT_W-1:0]     accept_cnt;
  logic [CNT_W-1:0]     reject_cnt;
  logic [PER_W-1:0]     period;
  logic                 period_valid;
  modport master (
    output din, enable, holdoff, clear,
    input  edge_pulse, busy, accept_cnt, reject_cnt, period, period_valid
  );
  modport slave (
    input  din, enable, holdoff, clear,
    output edge_pulse, busy, accept_cnt, reject_cnt, period, period_valid
  );
endinterface

// File: rtl/debounce_edge_qualifier.sv
// debounce_edge_qualifier: rising-edge qualifier with hold-off, saturating edge counts and edge-to-edge period
module debounce_edge_qualifier #(
  parameter int HOLDOFF_W = 8,
  parameter int CNT_W     = 16,
  parameter int PER_W     = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  debounce_edge_qualifier_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
  state_t               r_state, w_next;
  logic                 r_din_q, r_armed, r_first_seen, r_edge_pulse, r_period_valid;
  logic [HOLDOFF_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0]     r_accept_cnt, r_reject_cnt;
  logic [PER_W-1:0]     r_per_cnt, r_period, w_per_inc;
  logic                 w_rise, w_accept, w_reject, w_busy;
  // r_armed blocks a level that is already high when reset releases from counting as an edge
  assign w_rise    = bus.din & ~r_din_q & r_armed;
  assign w_per_inc = &r_per_cnt ? r_per_cnt : r_per_cnt + 1'b1;
  assign bus.edge_pulse   = r_edge_pulse;
  assign bus.period_valid = r_period_valid;
  assign bus.busy         = w_busy;
  assign bus.accept_cnt   = r_accept_cnt;
  assign bus.reject_cnt   = r_reject_cnt;
  assign bus.period       = r_period;
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // next state: HOLD is entered only with a nonzero count and leaves as the count reaches zero
  always_comb begin
    w_next = r_state;
    if (bus.clear)             w_next = IDLE;
    else if (r_state == IDLE)  w_next = (w_accept && bus.holdoff != '0) ? HOLD : IDLE;
    else                       w_next = (r_hold_cnt == HOLDOFF_W'(1)) ? IDLE : HOLD;
  end
  // state decode: clear overrides any coincident rise
  always_comb begin
    w_accept = (r_state == IDLE) & w_rise & bus.enable & ~bus.clear;
    w_reject = (r_state == HOLD) & w_rise & bus.enable & ~bus.clear;
    w_busy   = (r_state == HOLD);
  end
  // level history for edge detection, kept running through clear to avoid re-triggering
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_din_q <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_din_q <= bus.din;
      r_armed <= r_armed | ~bus.din;
    end
  end
  // hold-off countdown, loaded with the holdoff value captured at accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_hold_cnt <= '0;
    else if (bus.clear)         r_hold_cnt <= '0;
    else if (w_accept)          r_hold_cnt <= bus.holdoff;
    else if (r_state == HOLD)   r_hold_cnt <= r_hold_cnt - 1'b1;
  end
  // saturating accepted/rejected counters and the one-cycle edge pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_accept_cnt <= '0;
      r_reject_cnt <= '0;
      r_edge_pulse <= 1'b0;
    end else if (bus.clear) begin
      r_accept_cnt <= '0;
      r_reject_cnt <= '0;
      r_edge_pulse <= 1'b0;
    end else begin
      r_accept_cnt <= (w_accept && !(&r_accept_cnt)) ? r_accept_cnt + 1'b1 : r_accept_cnt;
      r_reject_cnt <= (w_reject && !(&r_reject_cnt)) ? r_reject_cnt + 1'b1 : r_reject_cnt;
      r_edge_pulse <= w_accept;
    end
  end
  // edge-to-edge period: the first accept only arms the measurement
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_per_cnt      <= '0;
      r_period       <= '0;
      r_first_seen   <= 1'b0;
      r_period_valid <= 1'b0;
    end else if (bus.clear) begin
      r_per_cnt      <= '0;
      r_period       <= '0;
      r_first_seen   <= 1'b0;
      r_period_valid <= 1'b0;
    end else begin
      r_per_cnt      <= w_accept ? '0 : w_per_inc;
      r_period       <= (w_accept && r_first_seen) ? w_per_inc : r_period;
      r_first_seen   <= r_first_seen | w_accept;
      r_period_valid <= w_accept & r_first_seen;
    end
  end
endmodule

// File: tb/tb_debounce_edge_qualifier.sv
// tb_debounce_edge_qualifier: directed scenarios with hand-computed expectations, narrow counters to reach saturation
module tb_debounce_edge_qualifier;
  localparam int HW = 8;
  localparam int CW = 4;
  localparam int PW = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  debounce_edge_qualifier_if #(.HOLDOFF_W(HW), .CNT_W(CW), .PER_W(PW)) bus ();
  debounce_edge_qualifier #(.HOLDOFF_W(HW), .CNT_W(CW), .PER_W(PW)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_clear();
    bus.din = 1'b0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      bus.din = i[0];
      tick();
    end
    n_checks++; if (bus.edge_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse got %0b exp 0", bus.edge_pulse); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b exp 0", bus.busy); end
    n_checks++; if (bus.accept_cnt !== 4'd0 || bus.reject_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnts got %0d/%0d exp 0/0", bus.accept_cnt, bus.reject_cnt); end
    n_checks++; if (bus.period !== 4'd0 || bus.period_valid !== 1'b0) begin n_fail++; $display("FAIL rst_period got %0d/%0b exp 0/0", bus.period, bus.period_valid); end
    bus.din = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.edge_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_high_release got %0b exp 0 (cycle %0d)", bus.edge_pulse, i); end
    end
    bus.din = 1'b0;
    tick();
    bus.din = 1'b1;
    tick();
    n_checks++; if (bus.edge_pulse !== 1'b1) begin n_fail++; $display("FAIL rst_first_edge got %0b exp 1", bus.edge_pulse); end
    n_checks++; if (bus.accept_cnt !== 4'd1) begin n_fail++; $display("FAIL rst_first_cnt got %0d exp 1", bus.accept_cnt); end
  endtask
  task automatic test_single_edge();
    int busy_cycles;
    do_clear();
    bus.holdoff = 8'd3;
    tick();
    bus.din = 1'b1;
    tick();
    n_checks++; if (bus.edge_pulse !== 1'b1) begin n_fail++; $display("FAIL single_pulse got %0b exp 1", bus.edge_pulse); end
    n_checks++; if (bus.period_valid !== 1'b0) begin n_fail++; $display("FAIL single_pv got %0b exp 0", bus.period_valid); end
    busy_cycles = bus.busy ? 1 : 0;
    tick();
    n_checks++; if (bus.edge_pulse !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width got %0b exp 0", bus.edge_pulse); end
    for (int i = 0; i < 5; i++) begin
      busy_cycles += bus.busy ? 1 : 0;
      tick();
    end
    n_checks++; if (busy_cycles != 3) begin n_fail++; $display("FAIL single_busy_cycles got %0d exp 3", busy_cycles); end
    n_checks++; if (bus.accept_cnt !== 4'd1 || bus.reject_cnt !== 4'd0) begin n_fail++; $display("FAIL single_cnts got %0d/%0d exp 1/0", bus.accept_cnt, bus.reject_cnt); end
  endtask
  task automatic test_holdoff_reject();
    do_clear();
    bus.holdoff = 8'd3;
    tick();
    bus.din = 1'b1; tick();
    bus.din = 1'b0; tick();
    bus.din = 1'b1; tick();
    n_checks++; if (bus.edge_pulse !== 1'b0 || bus.reject_cnt !== 4'd1) begin n_fail++; $display("FAIL hold_reject got pulse %0b rej %0d exp 0/1", bus.edge_pulse, bus.reject_cnt); end
    bus.din = 1'b0; tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL hold_end_busy got %0b exp 0", bus.busy); end
    bus.din = 1'b1; tick();
    n_checks++; if (bus.edge_pulse !== 1'b1 || bus.period_valid !== 1'b1) begin n_fail++; $display("FAIL hold_reaccept got pulse %0b pv %0b exp 1/1", bus.edge_pulse, bus.period_valid); end
    n_checks++; if (bus.period !== 4'd4) begin n_fail++; $display("FAIL hold_period got %0d exp 4", bus.period); end
    n_checks++; if (bus.accept_cnt !== 4'd2 || bus.reject_cnt !== 4'd1) begin n_fail++; $display("FAIL hold_cnts got %0d/%0d exp 2/1", bus.accept_cnt, bus.reject_cnt); end
  endtask
  task automatic test_period_enable();
    int pulses;
    do_clear();
    bus.holdoff = 8'd0;
    tick();
    for (int a = 0; a < 3; a++) begin
      bus.din = 1'b1;
      tick();
      n_checks++; if (bus.edge_pulse !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL per_pulse%0d got pulse %0b busy %0b exp 1/0", a, bus.edge_pulse, bus.busy); end
      n_checks++; if (bus.period_valid !== (a != 0)) begin n_fail++; $display("FAIL per_pv%0d got %0b exp %0b", a, bus.period_valid, a != 0); end
      n_checks++; if (bus.period !== (a != 0 ? 4'd10 : 4'd0)) begin n_fail++; $display("FAIL per_val%0d got %0d exp %0d", a, bus.period, a != 0 ? 10 : 0); end
      bus.din = 1'b0;
      repeat (9) tick();
    end
    bus.enable = 1'b0;
    bus.din = 1'b1; tick();
    n_checks++; if (bus.edge_pulse !== 1'b0) begin n_fail++; $display("FAIL dis_pulse got %0b exp 0", bus.edge_pulse); end
    bus.din = 1'b0; tick();
    bus.din = 1'b1; tick();
    n_checks++; if (bus.accept_cnt !== 4'd3 || bus.reject_cnt !== 4'd0) begin n_fail++; $display("FAIL dis_cnts got %0d/%0d exp 3/0", bus.accept_cnt, bus.reject_cnt); end
    bus.din = 1'b0; tick();
    bus.enable = 1'b1;
    bus.din = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += bus.edge_pulse ? 1 : 0;
    end
    n_checks++; if (pulses != 1 || bus.accept_cnt !== 4'd4) begin n_fail++; $display("FAIL held_high got %0d pulses cnt %0d exp 1/4", pulses, bus.accept_cnt); end
  endtask
  task automatic test_saturation();
    do_clear();
    bus.holdoff = 8'd0;
    tick();
    bus.din = 1'b1; tick();
    bus.din = 1'b0;
    repeat (20) tick();
    bus.din = 1'b1; tick();
    n_checks++; if (bus.period !== 4'd15 || bus.period_valid !== 1'b1) begin n_fail++; $display("FAIL sat_period got %0d pv %0b exp 15/1", bus.period, bus.period_valid); end
    bus.din = 1'b0; tick();
    for (int i = 0; i < 21; i++) begin
      bus.din = 1'b1; tick();
      bus.din = 1'b0; tick();
    end
    n_checks++; if (bus.accept_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_accept got %0d exp 15", bus.accept_cnt); end
    n_checks++; if (bus.period !== 4'd2) begin n_fail++; $display("FAIL sat_short_period got %0d exp 2", bus.period); end
    bus.holdoff = 8'd100;
    bus.din = 1'b1; tick();
    for (int i = 0; i < 20; i++) begin
      bus.din = 1'b0; tick();
      bus.din = 1'b1; tick();
    end
    n_checks++; if (bus.reject_cnt !== 4'd15 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL sat_reject got %0d busy %0b exp 15/1", bus.reject_cnt, bus.busy); end
  endtask
  task automatic test_clear_reset();
    do_clear();
    bus.holdoff = 8'd0;
    tick();
    bus.din = 1'b1;
    bus.clear = 1'b1;
    tick();
    n_checks++; if (bus.edge_pulse !== 1'b0 || bus.accept_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_rise got pulse %0b cnt %0d exp 0/0", bus.edge_pulse, bus.accept_cnt); end
    bus.clear = 1'b0;
    tick();
    n_checks++; if (bus.edge_pulse !== 1'b0 || bus.accept_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_retrig got pulse %0b cnt %0d exp 0/0", bus.edge_pulse, bus.accept_cnt); end
    bus.din = 1'b0; tick();
    bus.holdoff = 8'd5;
    bus.din = 1'b1; tick();
    tick();
    n_checks++; if (bus.busy !== 1'b1 || bus.accept_cnt !== 4'd1) begin n_fail++; $display("FAIL rst_mid_pre got busy %0b cnt %0d exp 1/1", bus.busy, bus.accept_cnt); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.accept_cnt !== 4'd0 || bus.reject_cnt !== 4'd0 || bus.period !== 4'd0) begin n_fail++; $display("FAIL rst_mid got busy %0b acc %0d rej %0d per %0d exp all 0", bus.busy, bus.accept_cnt, bus.reject_cnt, bus.period); end
    #2;
    reset_n = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.edge_pulse !== 1'b0 || bus.busy !== 1'b0 || bus.accept_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_mid_release got pulse %0b busy %0b cnt %0d exp 0/0/0", bus.edge_pulse, bus.busy, bus.accept_cnt); end
  endtask
  initial begin
    bus.din = 1'b0;
    bus.enable = 1'b1;
    bus.holdoff = 8'd0;
    bus.clear = 1'b0;
    test_reset();
    test_single_edge();
    test_holdoff_reject();
    test_period_enable();
    test_saturation();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
